// File: rtl/ex_muldiv_pkg.sv
// rtl/ex_muldiv_pkg.sv - shared encodings and helpers for the iterative multiply/divide unit
package ex_muldiv_pkg;

    localparam logic RstEnable = 1'b1;

    localparam int DefDataW = 32;
    localparam int DefCntW  = 6;

    localparam logic [1:0] MulOp   = 2'd0;
    localparam logic [1:0] MultuOp = 2'd1;
    localparam logic [1:0] DivOp   = 2'd2;
    localparam logic [1:0] DivuOp  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_BUSY   = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == DivOp) || (op == DivuOp);
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        logic s;
        case (op)
            MulOp, DivOp:    s = 1'b1;
            MultuOp, DivuOp: s = 1'b0;
            default:         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ex_muldiv_iter.sv
// rtl/ex_muldiv_iter.sv - one radix-2 step: shift-add multiply or restoring divide
module ex_muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic                is_div_i,
    input  logic [2*DATA_W:0]   work_i,
    input  logic [DATA_W-1:0]   opnd_i,
    output logic [2*DATA_W:0]   work_o
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    // Multiply: work = {carry, hi, lo}; lo starts as the multiplier and shifts out LSB first.
    // Divide: work[2W-1:W] is the partial remainder, quotient bits shift in at the bottom.
    always_comb begin
        sum  = work_i[2*DATA_W:DATA_W]
             + (work_i[0] ? {1'b0, opnd_i} : {(DATA_W+1){1'b0}});
        diff = {1'b0, work_i[2*DATA_W-1:DATA_W]} - {1'b0, opnd_i};
        if (is_div_i) begin
            if (diff[DATA_W]) begin
                work_o = {work_i[2*DATA_W-1:0], 1'b0};
            end else begin
                work_o = {diff[DATA_W-1:0], work_i[DATA_W-1:0], 1'b1};
            end
        end else begin
            work_o = {1'b0, sum, work_i[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - multi-cycle MULT/MULTU/DIV/DIVU unit returning {HI,LO} with stall request
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W = DefDataW,
    parameter int CNT_W  = DefCntW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [1:0]            op_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq_o
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W:0]      work_q, work_d, work_step;
    logic [DATA_W-1:0]      opnd_q, opnd_d;
    logic                   is_div_q, is_div_d;
    logic                   sign1_q, sign1_d;
    logic                   sign2_q, sign2_d;
    logic [2*DATA_W-1:0]    result_q, result_d;
    logic                   ready_q, ready_d;

    logic                   in_sign1, in_sign2;
    logic [DATA_W-1:0]      in_abs1, in_abs2;
    logic [2*DATA_W-1:0]    prod_fix, final_res;
    logic [DATA_W-1:0]      quot_fix, rem_fix;

    ex_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
        .is_div_i (is_div_q),
        .work_i   (work_q),
        .opnd_i   (opnd_q),
        .work_o   (work_step)
    );

    always_comb begin
        in_sign1 = op_is_signed(op_i) & opdata1_i[DATA_W-1];
        in_sign2 = op_is_signed(op_i) & opdata2_i[DATA_W-1];
        in_abs1  = in_sign1 ? -opdata1_i : opdata1_i;
        in_abs2  = in_sign2 ? -opdata2_i : opdata2_i;
    end

    // Sign flags are only ever set for signed ops, so unsigned results pass through untouched.
    always_comb begin
        prod_fix  = (sign1_q ^ sign2_q) ? -work_q[2*DATA_W-1:0] : work_q[2*DATA_W-1:0];
        quot_fix  = (sign1_q ^ sign2_q) ? -work_q[DATA_W-1:0] : work_q[DATA_W-1:0];
        rem_fix   = sign1_q ? -work_q[2*DATA_W:DATA_W+1] : work_q[2*DATA_W:DATA_W+1];
        final_res = is_div_q ? {rem_fix, quot_fix} : prod_fix;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        opnd_d   = opnd_q;
        is_div_d = is_div_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        result_d = result_q;
        ready_d  = ready_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b0;
                if (start_i && !annul_i) begin
                    if (op_is_div(op_i) && (opdata2_i == '0)) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d  = S_BUSY;
                        cnt_d    = '0;
                        is_div_d = op_is_div(op_i);
                        sign1_d  = in_sign1;
                        sign2_d  = in_sign2;
                        if (op_is_div(op_i)) begin
                            work_d = {{DATA_W{1'b0}}, in_abs1, 1'b0};
                            opnd_d = in_abs2;
                        end else begin
                            work_d = {{(DATA_W+1){1'b0}}, in_abs2};
                            opnd_d = in_abs1;
                        end
                    end
                end
            end
            S_BYZERO: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_DONE;
                    result_d = '0;
                    ready_d  = 1'b1;
                end
            end
            S_BUSY: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    work_d = work_step;
                    cnt_d  = cnt_q + CNT_W'(1);
                end else begin
                    state_d  = S_DONE;
                    result_d = final_res;
                    ready_d  = 1'b1;
                end
            end
            S_DONE: begin
                if (annul_i || !start_i) begin
                    state_d = S_IDLE;
                    ready_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            work_q   <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            work_q   <= work_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            result_q <= result_d;
            ready_q  <= ready_d;
        end
    end

    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] exp_q[$];
    int          lat_q[$];

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .opdata1_i  (opdata1_i),
        .opdata2_i  (opdata2_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .ready_o    (ready_o),
        .stallreq_o (stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        int     q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            MulOp:   res = sa * sb;
            MultuOp: res = {32'h0, a} * {32'h0, b};
            DivOp: begin
                if (b == 32'h0) res = 64'h0;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'h0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) % $signed(b);
                    res = {r, q};
                end
            end
            default: begin
                if (b == 32'h0) res = 64'h0;
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int          cyc;
        logic        stall_ok;
        logic [63:0] held;
        op_i      = op;
        opdata1_i = a;
        opdata2_i = b;
        annul_i   = 1'b0;
        start_i   = 1'b1;
        exp_q.push_back(model(op, a, b));
        lat_q.push_back((op[1] && b == 32'h0) ? 2 : 34);
        #1;
        cyc      = 0;
        stall_ok = 1'b1;
        while (!ready_o && cyc < 100) begin
            if (!stallreq_o) stall_ok = 1'b0;
            tick();
            cyc++;
            if (cyc == 3) begin
                opdata1_i = ~a;
                opdata2_i = ~b;
                op_i      = ~op;
            end
        end
        check({tag, " stall"}, 64'(stall_ok), 64'h1);
        check({tag, " latency"}, 64'(cyc), 64'(lat_q.pop_front()));
        check({tag, " result"}, result_o, exp_q.pop_front());
        check({tag, " stall_done"}, 64'(stallreq_o), 64'h0);
        held    = result_o;
        start_i = 1'b0;
        tick();
        check({tag, " ready_drop"}, 64'(ready_o), 64'h0);
        check({tag, " held"}, result_o, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        rst       = 1'b1;
        start_i   = 1'b0;
        annul_i   = 1'b0;
        op_i      = 2'd0;
        opdata1_i = 32'h0;
        opdata2_i = 32'h0;
        tick();
        tick();
        check("reset result", result_o, 64'h0);
        check("reset ready", 64'(ready_o), 64'h0);
        check("reset stall", 64'(stallreq_o), 64'h0);
        rst = 1'b0;
        tick();

        run_op("mult_neg",   MulOp,   32'hFFFF_FFFE, 32'h0000_0003);
        run_op("multu_max",  MultuOp, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg",    DivOp,   32'hFFFF_FFF9, 32'h0000_0002);
        run_op("divu_100_7", DivuOp,  32'd100,       32'd7);
        run_op("divu_zero",  DivuOp,  32'h1234_5678, 32'h0);
        run_op("div_wrap",   DivOp,   32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero",   DivOp,   32'hFFFF_0000, 32'h0);

        // Annul mid-BUSY with start held: must return to IDLE and not re-accept while annulled.
        op_i = MulOp; opdata1_i = 32'd1234; opdata2_i = 32'd5678; start_i = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        annul_i = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ready_o) seen = 1'b1;
        end
        check("annul no_ready", 64'(seen), 64'h0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();
        run_op("after_annul", MultuOp, 32'd3, 32'd5);

        op_i = DivuOp; opdata1_i = 32'd999; opdata2_i = 32'd10; start_i = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst result", result_o, 64'h0);
        check("midrst ready", 64'(ready_o), 64'h0);
        check("midrst stall", 64'(stallreq_o), 64'h1);
        rst     = 1'b0;
        start_i = 1'b0;
        #1;
        check("midrst stall_low", 64'(stallreq_o), 64'h0);
        tick();

        for (int i = 0; i < 8; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i == 5) ? 32'h0 : ((i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300)));
            run_op($sformatf("rand%0d", i), rop, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
